// File: rtl/run_ctrl.sv
// Run/step controller: synchronises the start button, divides clk down to a
// one-cycle CPU enable, and tracks IDLE/RUN/HALTED plus retirement counters.
module run_ctrl #(
  parameter int unsigned DIV_0 = 1,
  parameter int unsigned DIV_1 = 4,
  parameter int unsigned DIV_2 = 1_000_000,
  parameter int unsigned DIV_3 = 25_000_000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        go,
  input  logic [1:0]  hz_sel,
  input  logic        halt_req,
  input  logic        br_taken,
  input  logic        is_jmp,
  output logic        cpu_en,
  output logic        clk_n,
  output logic [1:0]  run_state,
  output logic [31:0] cnt_all,
  output logic [31:0] cnt_branch,
  output logic [31:0] cnt_jmp
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10
  } state_t;

  // Terminal counts are stored as DIV-1 so that a ratio of 2^26 still fits.
  localparam logic [25:0] MAX_0 = 26'(DIV_0 - 1);
  localparam logic [25:0] MAX_1 = 26'(DIV_1 - 1);
  localparam logic [25:0] MAX_2 = 26'(DIV_2 - 1);
  localparam logic [25:0] MAX_3 = 26'(DIV_3 - 1);

  function automatic logic [25:0] div_max(input logic [1:0] sel);
    case (sel)
      2'd0:    div_max = MAX_0;
      2'd1:    div_max = MAX_1;
      2'd2:    div_max = MAX_2;
      default: div_max = MAX_3;
    endcase
  endfunction

  state_t      state;
  state_t      state_nxt;
  logic        go_p0, go_p1, go_p2;
  logic        vld_p0, vld_p1, vld_p2;
  logic        go_rise;
  logic [1:0]  hz_q;
  logic        hz_chg;
  logic [25:0] div_cnt;
  logic [25:0] div_nxt;
  logic        pulse_nxt;
  logic        halting;

  // Stage p0/p1: two-flop synchroniser; p2: edge register. The vld_pN chain
  // marks when go_p2 holds a real post-reset sample, so a button already held
  // at reset release never looks like a fresh press.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      go_p0  <= 1'b0;
      go_p1  <= 1'b0;
      go_p2  <= 1'b0;
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      go_p0  <= go;
      go_p1  <= go_p0;
      go_p2  <= go_p1;
      vld_p0 <= 1'b1;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  assign go_rise = go_p1 & ~go_p2 & vld_p2;
  assign hz_chg  = (hz_sel != hz_q);
  assign halting = (state == RUN) & cpu_en & halt_req;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go_rise) state_nxt = RUN;
      RUN:     if (halting) state_nxt = HALTED;
      HALTED:  if (go_rise) state_nxt = RUN;
      default: state_nxt = go_rise ? RUN : IDLE;
    endcase
  end

  // The enable is decided one cycle ahead so cpu_en comes straight from a flop.
  always_comb begin
    pulse_nxt = 1'b0;
    div_nxt   = 26'd0;
    if ((state == RUN) && !hz_chg && !halting) begin
      if (div_cnt == div_max(hz_q)) begin
        pulse_nxt = 1'b1;
      end else begin
        div_nxt = div_cnt + 26'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= IDLE;
      hz_q    <= 2'b00;
      div_cnt <= 26'd0;
      cpu_en  <= 1'b0;
      clk_n   <= 1'b0;
    end else begin
      state   <= state_nxt;
      hz_q    <= hz_sel;
      div_cnt <= div_nxt;
      cpu_en  <= pulse_nxt;
      clk_n   <= clk_n ^ pulse_nxt;
    end
  end

  // Retirement counters advance on the enable cycle itself, halting one included.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_all    <= 32'd0;
      cnt_branch <= 32'd0;
      cnt_jmp    <= 32'd0;
    end else if (cpu_en) begin
      cnt_all <= cnt_all + 32'd1;
      if (br_taken) cnt_branch <= cnt_branch + 32'd1;
      if (is_jmp)   cnt_jmp    <= cnt_jmp + 32'd1;
    end
  end

  assign run_state = (state == RUN)    ? 2'b01 :
                     (state == HALTED) ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_run_ctrl.sv
// Scoreboard bench for run_ctrl: expected enable pulses are queued up front,
// a negedge monitor checks each pulse's cycle, counters and clk_n.
module tb_run_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic        go;
  logic [1:0]  hz_sel;
  logic        halt_req;
  logic        br_taken;
  logic        is_jmp;
  logic        cpu_en;
  logic        clk_n;
  logic [1:0]  run_state;
  logic [31:0] cnt_all;
  logic [31:0] cnt_branch;
  logic [31:0] cnt_jmp;

  always #5 clk = ~clk;

  run_ctrl dut (
    .clk        (clk),
    .clr        (clr),
    .go         (go),
    .hz_sel     (hz_sel),
    .halt_req   (halt_req),
    .br_taken   (br_taken),
    .is_jmp     (is_jmp),
    .cpu_en     (cpu_en),
    .clk_n      (clk_n),
    .run_state  (run_state),
    .cnt_all    (cnt_all),
    .cnt_branch (cnt_branch),
    .cnt_jmp    (cnt_jmp)
  );

  typedef struct {
    int          at;
    logic [31:0] all;
    logic [31:0] br;
    logic [31:0] jmp;
    logic        clkn;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   base        = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc - base);
    end
  endtask

  task automatic push(input int at, input logic [31:0] all, input logic [31:0] br,
                      input logic [31:0] jmp, input int n);
    exp_t e;
    e.at   = at;
    e.all  = all;
    e.br   = br;
    e.jmp  = jmp;
    e.clkn = ((n % 2) == 0);
    exp_q.push_back(e);
  endtask

  task automatic to_cycle(input int k);
    while ((cyc - base) < k) @(negedge clk);
  endtask

  // Monitor: every enable pulse must match the next queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (clr === 1'b0 && cpu_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pulse: cpu_en=1 at cycle %0d, expected 0", cyc - base);
      end else begin
        e = exp_q.pop_front();
        check("pulse_cycle", 32'(cyc - base), 32'(e.at));
        check("pulse_cnt_all", cnt_all, e.all);
        check("pulse_cnt_branch", cnt_branch, e.br);
        check("pulse_cnt_jmp", cnt_jmp, e.jmp);
        check("pulse_clk_n", 32'(clk_n), 32'(e.clkn));
      end
    end
  end

  initial begin
    clr = 1'b1; go = 1'b0; hz_sel = 2'd0;
    halt_req = 1'b0; br_taken = 1'b0; is_jmp = 1'b0;

    // Hand-derived pulse schedule (cycle, counters seen during the pulse).
    for (int n = 0; n <= 6; n++)  push(14 + n, 32'(n), 0, 0, n);
    for (int n = 7; n <= 11; n++) push(33 + 4 * (n - 7), 32'(n), (n >= 9) ? 1 : 0, (n >= 9) ? 1 : 0, n);
    for (int n = 12; n <= 17; n++) push(54 + (n - 12), 32'(n), 1, 1, n);
    push(69, 32'hFFFF_FFFF, 1, 1, 18);
    push(70, 32'h0000_0000, 1, 1, 19);
    push(71, 32'h0000_0001, 1, 1, 20);

    repeat (3) @(negedge clk);
    check("rst_run_state", 32'(run_state), 0);
    check("rst_cpu_en", 32'(cpu_en), 0);
    check("rst_clk_n", 32'(clk_n), 0);
    check("rst_cnt_all", cnt_all, 0);
    check("rst_cnt_branch", cnt_branch, 0);
    check("rst_cnt_jmp", cnt_jmp, 0);

    clr  = 1'b0;
    base = cyc;

    to_cycle(10); go = 1'b1;
    to_cycle(12); check("start_still_idle", 32'(run_state), 0);
    to_cycle(13); check("start_run", 32'(run_state), 1);
                  check("start_no_pulse_yet", 32'(cpu_en), 0);

    to_cycle(20); halt_req = 1'b1;
    to_cycle(21); halt_req = 1'b0;
                  check("halt_state", 32'(run_state), 2);
                  check("halt_cnt_all", cnt_all, 7);
                  check("halt_cpu_en", 32'(cpu_en), 0);
                  go = 1'b0;
    to_cycle(22); hz_sel = 2'd1;
    to_cycle(25); check("halted_hold", 32'(run_state), 2);
    to_cycle(26); go = 1'b1;
    to_cycle(28); check("resume_not_yet", 32'(run_state), 2);
    to_cycle(29); check("resume_run", 32'(run_state), 1);

    to_cycle(37); br_taken = 1'b1; is_jmp = 1'b1;
    to_cycle(38); is_jmp = 1'b0;
    to_cycle(41); br_taken = 1'b0;
    to_cycle(42); halt_req = 1'b1;
    to_cycle(45); halt_req = 1'b0;
    to_cycle(46); check("halt_ignored_off_pulse", 32'(run_state), 1);
    to_cycle(50); check("div4_cnt_all", cnt_all, 12);

    to_cycle(52); hz_sel = 2'd0;
    to_cycle(53); check("rate_change_no_pulse", 32'(cpu_en), 0);
    to_cycle(59); halt_req = 1'b1;
    to_cycle(60); halt_req = 1'b0;
                  check("halt2_state", 32'(run_state), 2);
                  check("halt2_cnt_all", cnt_all, 18);
                  check("halt2_cnt_branch", cnt_branch, 1);
                  check("halt2_cnt_jmp", cnt_jmp, 1);
                  go = 1'b0;
    to_cycle(61); force dut.cnt_all = 32'hFFFF_FFFF;
    to_cycle(62); release dut.cnt_all;
    to_cycle(63); check("forced_hold", cnt_all, 32'hFFFF_FFFF);
    to_cycle(65); go = 1'b1;

    to_cycle(71);
    @(posedge clk);
    #2 clr = 1'b1;
    #1;
    check("midrun_clr_state", 32'(run_state), 0);
    check("midrun_clr_cpu_en", 32'(cpu_en), 0);
    check("midrun_clr_clk_n", 32'(clk_n), 0);
    check("midrun_clr_cnt_all", cnt_all, 0);
    check("midrun_clr_cnt_branch", cnt_branch, 0);
    check("midrun_clr_cnt_jmp", cnt_jmp, 0);
    @(negedge clk);
    clr = 1'b0;
    repeat (10) @(negedge clk);
    check("held_go_no_start", 32'(run_state), 0);
    check("held_go_no_pulse", 32'(cpu_en), 0);
    check("all_pulses_seen", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
